// File: rtl/rotation_aligner.sv
// Rotation aligner: finds the link's constant left-rotation from tagged sync words and rotates data back.
// Optional ROTATION_ALIGNER_STATS_EN adds a saturating slip_count of LOCKED->SEARCH events.
module rotation_aligner #(
  parameter int          WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hB5,
  parameter int          LOCK_CNT  = 3,
  parameter int          MISS_CNT  = 2,
  localparam int         OW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_sync,
  output logic [WIDTH-1:0] out_data,
  output logic             locked,
`ifdef ROTATION_ALIGNER_STATS_EN
  output logic [7:0]       slip_count,
`endif
  output logic [OW-1:0]    offset
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;

  localparam logic [3:0]    LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0]    MISS_C = 4'(MISS_CNT);
  localparam logic [OW-1:0] OFF_MAX = OW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [OW-1:0]    offset_q, offset_d, offset_inc;
  logic [3:0]       match_cnt_q, match_cnt_d, miss_cnt_q, miss_cnt_d;
  logic             out_valid_q, out_sync_q, locked_q;
  logic [WIDTH-1:0] out_data_q;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0] rot;
  logic             chk, match;

  // Rotate right via a doubled word so offset 0 needs no special case.
  assign dbl        = {in_data, in_data} >> offset_q;
  assign rot        = dbl[WIDTH-1:0];
  assign chk        = in_valid & in_sync;
  assign match      = (rot == SYNC_WORD);
  assign offset_inc = (offset_q == OFF_MAX) ? '0 : offset_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (chk) begin
      unique case (state_q)
        SEARCH: begin
          if (match) begin
            match_cnt_d = 4'd1;
            miss_cnt_d  = '0;
            state_d     = (LOCK_C == 4'd1) ? LOCKED : VERIFY;
          end else begin
            offset_d = offset_inc;
          end
        end
        VERIFY: begin
          if (match) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_d == LOCK_C) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            state_d     = SEARCH;
            offset_d    = offset_inc;
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_cnt_d = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_d == MISS_C) begin
              state_d     = SEARCH;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      offset_q    <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      out_data_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= (state_d == LOCKED);
      // The locking word is emitted; the word that drops lock is not.
      out_valid_q <= in_valid & (state_d == LOCKED);
      if (in_valid && state_d == LOCKED) begin
        out_data_q <= rot;
        out_sync_q <= in_sync;
      end
    end
  end

`ifdef ROTATION_ALIGNER_STATS_EN
  logic [7:0] slip_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      slip_q <= '0;
    else if (state_q == LOCKED && state_d == SEARCH && slip_q != 8'hFF)
      slip_q <= slip_q + 8'd1;
  end
  assign slip_count = slip_q;
`endif

  assign out_valid = out_valid_q;
  assign out_sync  = out_sync_q;
  assign out_data  = out_data_q;
  assign locked    = locked_q;
  assign offset    = offset_q;

endmodule

// File: tb/tb_rotation_aligner.sv
// Directed bench for rotation_aligner (WIDTH=8, SYNC=B5, LOCK_CNT=3, MISS_CNT=2).
module tb_rotation_aligner;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_sync;
  logic [7:0] in_data;
  logic       out_valid, out_sync, locked;
  logic [7:0] out_data;
  logic [2:0] offset;
`ifdef ROTATION_ALIGNER_STATS_EN
  logic [7:0] slip_count;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rotation_aligner #(.WIDTH(8), .SYNC_WORD(8'hB5), .LOCK_CNT(3), .MISS_CNT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data),
    .out_valid(out_valid), .out_sync(out_sync), .out_data(out_data), .locked(locked),
`ifdef ROTATION_ALIGNER_STATS_EN
    .slip_count(slip_count),
`endif
    .offset(offset));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one word for one edge, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    in_valid = v; in_sync = s; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic l, input logic [2:0] o, input logic ov);
    chk({tag, ".locked"}, 32'(locked), 32'(l));
    chk({tag, ".offset"}, 32'(offset), 32'(o));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
  endtask

  task automatic acquire;
    step(1, 1, 8'hAD); chk_st("acq1", 0, 1, 0);
    step(1, 1, 8'hAD); chk_st("acq2", 0, 2, 0);
    step(1, 1, 8'hAD); chk_st("acq3", 0, 3, 0);
    step(1, 1, 8'hAD); chk_st("acq4", 0, 3, 0);
    step(1, 1, 8'hAD); chk_st("acq5", 0, 3, 0);
    step(1, 1, 8'hAD); chk_st("acq6", 1, 3, 1);
    chk("acq6.out_data", 32'(out_data), 32'h B5);
    chk("acq6.out_sync", 32'(out_sync), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_sync = 0; in_data = 8'h00;
    #2;
    chk_st("rst0", 0, 0, 0);
    chk("rst0.out_data", 32'(out_data), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    acquire();

    // Data path after lock
    step(1, 0, 8'h90); chk_st("data", 1, 3, 1);
    chk("data.out_data", 32'(out_data), 32'h12);
    chk("data.out_sync", 32'(out_sync), 32'd0);
    step(0, 1, 8'hFF); chk_st("bubble", 1, 3, 0);
    chk("bubble.out_data", 32'(out_data), 32'h12);

    // Loss of lock
    step(1, 1, 8'hFF); chk_st("miss1", 1, 3, 1);
    chk("miss1.out_data", 32'(out_data), 32'hFF);
    step(1, 1, 8'hAD); chk_st("rematch", 1, 3, 1);
    chk("rematch.out_data", 32'(out_data), 32'hB5);
    step(1, 1, 8'hFF); chk_st("miss2a", 1, 3, 1);
    step(1, 1, 8'hFF); chk_st("miss2b", 0, 3, 0);
    chk("miss2b.out_data", 32'(out_data), 32'hFF);
`ifdef ROTATION_ALIGNER_STATS_EN
    chk("slip_count", 32'(slip_count), 32'd1);
`endif

    // Verify abort from SEARCH at offset 3
    step(1, 1, 8'hAD); chk_st("vab1", 0, 3, 0);
    step(1, 1, 8'hAD); chk_st("vab2", 0, 3, 0);
    step(1, 1, 8'h00); chk_st("vab3", 0, 4, 0);

    // Wrap and ignore
    step(1, 1, 8'h00); step(1, 1, 8'h00); step(1, 1, 8'h00);
    chk_st("off7", 0, 7, 0);
    step(1, 0, 8'h00); chk_st("nosync", 0, 7, 0);
    step(0, 1, 8'h00); chk_st("novalid", 0, 7, 0);
    step(1, 1, 8'h00); chk_st("wrap", 0, 0, 0);

    // Reacquire, then async reset mid-stream
    acquire();
    step(1, 0, 8'h90);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk_st("arst", 0, 0, 0);
    chk("arst.out_data", 32'(out_data), 32'h0);
    chk("arst.out_sync", 32'(out_sync), 32'h0);
`ifdef ROTATION_ALIGNER_STATS_EN
    chk("arst.slip", 32'(slip_count), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    // Partial match count must be discarded: 3 matches needed again at offset 0 -> never lock on AD
    step(1, 1, 8'hB5); chk_st("post1", 0, 0, 0);
    step(1, 1, 8'hB5); chk_st("post2", 0, 0, 0);
    step(1, 1, 8'hB5); chk_st("post3", 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
